// File: rtl/saes32_arb_pkg.sv
// Shared types, constants and the LFSR advance function
// for the saes32 issue arbiter.
package saes32_arb_pkg;

    typedef enum logic [1:0] {
        OP_ENCS  = 2'd0,
        OP_ENCSM = 2'd1,
        OP_DECS  = 2'd2,
        OP_DECSM = 2'd3
    } op_e;

    // Fibonacci taps 64,63,61,60 -> state bits 63,62,60,59
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam int RAND_BITS = 26;

    function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int i = 0; i < RAND_BITS; i++) begin
            r = {r[62:0], ^(r & LFSR_TAPS)};
        end
        return r;
    endfunction

endpackage

// File: rtl/saes32_mask_lfsr.sv
// Mask randomness source: 64-bit LFSR advanced 26 steps per issue,
// reseedable at run time.
module saes32_mask_lfsr
    import saes32_arb_pkg::*;
#(
    parameter logic [63:0] LFSR_RESET = 64'hACE1_2468_BDF1_3579
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 seed_load_i,
    input  logic [63:0]          seed_i,
    input  logic                 advance_i,
    output logic [RAND_BITS-1:0] randombits_o
);

    logic [63:0] lfsr_q;

    // Reseed wins over advance; an all-zero seed would lock up the LFSR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_RESET;
        end else if (seed_load_i) begin
            lfsr_q <= (seed_i == 64'd0) ? 64'd1 : seed_i;
        end else if (advance_i) begin
            lfsr_q <= lfsr_advance(lfsr_q);
        end
    end

    assign randombits_o = lfsr_q[RAND_BITS-1:0];

endmodule

// File: rtl/saes32_issue_arbiter.sv
// Two-requester round-robin issue arbiter with per-requester credit
// tracking and result routing for a shared saes32 unit.
module saes32_issue_arbiter
    import saes32_arb_pkg::*;
#(
    parameter int          X_ID_WIDTH      = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [63:0] LFSR_RESET      = 64'hACE1_2468_BDF1_3579
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [31:0]           req0_rs1_i,
    input  logic [31:0]           req0_rs2_i,
    input  logic [1:0]            req0_bs_i,
    input  logic [1:0]            req0_op_i,
    input  logic [X_ID_WIDTH-1:0] req0_id_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [31:0]           req1_rs1_i,
    input  logic [31:0]           req1_rs2_i,
    input  logic [1:0]            req1_bs_i,
    input  logic [1:0]            req1_op_i,
    input  logic [X_ID_WIDTH-1:0] req1_id_i,

    output logic                  fu_valid_o,
    input  logic                  fu_ready_i,
    output logic [31:0]           fu_rs1_o,
    output logic [31:0]           fu_rs2_o,
    output logic [1:0]            fu_bs_o,
    output logic                  fu_op_encs_o,
    output logic                  fu_op_encsm_o,
    output logic                  fu_op_decs_o,
    output logic                  fu_op_decsm_o,
    output logic [25:0]           fu_randombits_o,
    output logic [X_ID_WIDTH:0]   fu_id_o,

    input  logic [31:0]           fu_result_i,
    input  logic [X_ID_WIDTH:0]   fu_id_i,
    input  logic                  fu_valid_i,
    output logic                  fu_ready_o,

    output logic                  rsp0_valid_o,
    input  logic                  rsp0_ready_i,
    output logic [31:0]           rsp0_result_o,
    output logic [X_ID_WIDTH-1:0] rsp0_id_o,

    output logic                  rsp1_valid_o,
    input  logic                  rsp1_ready_i,
    output logic [31:0]           rsp1_result_o,
    output logic [X_ID_WIDTH-1:0] rsp1_id_o,

    input  logic                  seed_load_i,
    input  logic [63:0]           seed_i,

    output logic                  err_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [3:0] cnt_q [2];
    logic       ptr_q;
    logic       lock_q;
    logic       lock_gnt_q;
    logic       err_q;

    logic [1:0] req_valid;
    logic [1:0] elig;
    logic [1:0] iss_hs;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [1:0] rsp_hs;
    logic       gnt;
    logic       fu_hs;
    logic       rsp_sel;
    op_e        op;

    assign req_valid = {req1_valid_i, req0_valid_i};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n] = !rst_i && req_valid[n] && (cnt_q[n] < MAX_CNT);
        end
    end

    // A stalled issue keeps its grant until the FU accepts it
    always_comb begin
        gnt = ptr_q;
        if (lock_q) begin
            gnt = lock_gnt_q;
        end else if (elig[ptr_q]) begin
            gnt = ptr_q;
        end else if (elig[~ptr_q]) begin
            gnt = ~ptr_q;
        end
    end

    assign fu_valid_o   = (|elig) || lock_q;
    assign fu_hs        = fu_valid_o && fu_ready_i;
    assign req0_ready_o = fu_ready_i && !gnt && elig[0];
    assign req1_ready_o = fu_ready_i && gnt && elig[1];
    assign iss_hs       = {req1_valid_i && req1_ready_o,
                           req0_valid_i && req0_ready_o};

    assign fu_rs1_o = gnt ? req1_rs1_i : req0_rs1_i;
    assign fu_rs2_o = gnt ? req1_rs2_i : req0_rs2_i;
    assign fu_bs_o  = gnt ? req1_bs_i  : req0_bs_i;
    assign fu_id_o  = {gnt, gnt ? req1_id_i : req0_id_i};
    assign op       = op_e'(gnt ? req1_op_i : req0_op_i);

    assign fu_op_encs_o  = (op == OP_ENCS);
    assign fu_op_encsm_o = (op == OP_ENCSM);
    assign fu_op_decs_o  = (op == OP_DECS);
    assign fu_op_decsm_o = (op == OP_DECSM);

    assign rsp_sel      = fu_id_i[X_ID_WIDTH];
    assign rsp_ready    = {rsp1_ready_i, rsp0_ready_i};
    assign rsp_valid[0] = !rst_i && fu_valid_i && !rsp_sel;
    assign rsp_valid[1] = !rst_i && fu_valid_i && rsp_sel;
    assign rsp_hs       = rsp_valid & rsp_ready;
    assign fu_ready_o   = !rst_i && rsp_ready[rsp_sel];

    assign rsp0_valid_o  = rsp_valid[0];
    assign rsp1_valid_o  = rsp_valid[1];
    assign rsp0_result_o = fu_result_i;
    assign rsp1_result_o = fu_result_i;
    assign rsp0_id_o     = fu_id_i[X_ID_WIDTH-1:0];
    assign rsp1_id_o     = fu_id_i[X_ID_WIDTH-1:0];
    assign err_o         = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_gnt_q <= 1'b0;
        end else begin
            if (fu_hs) begin
                ptr_q <= ~gnt;
            end
            if (fu_valid_o && !fu_ready_i) begin
                lock_q     <= 1'b1;
                lock_gnt_q <= gnt;
            end else begin
                lock_q <= 1'b0;
            end
        end
    end

    // A result for a requester with nothing in flight is flagged, count floors at 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= 4'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (iss_hs[n] && !rsp_hs[n]) begin
                    cnt_q[n] <= cnt_q[n] + 4'd1;
                end else if (!iss_hs[n] && rsp_hs[n] && cnt_q[n] != 4'd0) begin
                    cnt_q[n] <= cnt_q[n] - 4'd1;
                end
                if (rsp_valid[n] && cnt_q[n] == 4'd0) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    saes32_mask_lfsr #(
        .LFSR_RESET (LFSR_RESET)
    ) u_lfsr (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_load_i  (seed_load_i),
        .seed_i       (seed_i),
        .advance_i    (fu_hs),
        .randombits_o (fu_randombits_o)
    );

endmodule
